pipe_hazard_sequencer: RTL and testbench
========================================

Name: pipe_hazard_sequencer

Overview:
Next-generation pipeline control sequencer for the pipelined Harvard CPU. It replaces the purely combinational flush/stall priority logic with a registered sequencer.
- Generalised to NUM_STAGES pipeline registers, with configurable branch-resolve and jump-resolve depths.
- Adds variable-latency memory freeze, a halt-drain state machine that cancels on wrong-path halts, and saturating stall/flush performance counters.
- Sits beside the decoder; drives per-pipeline-register write-enable and flush lines plus pc_write.

Parameters:
NUM_STAGES, 4, number of pipeline registers; index 0 = IF/ID, 1 = ID/EX, 2 = EX/MEM, NUM_STAGES-1 = MEM/WB; legal range 3..8
BR_STAGE, 2, index of the register whose instruction resolves branches; a branch mispredict flushes registers 0..BR_STAGE-1; must be ≥1 and < NUM_STAGES
JMP_STAGE, 1, index of the register whose instruction resolves jumps; a jump mispredict flushes registers 0..JMP_STAGE-1; must satisfy 1 ≤ JMP_STAGE ≤ BR_STAGE
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
branch_mispredict  in  1  branch in register BR_STAGE mispredicted
jump_mispredict  in  1  jump in register JMP_STAGE mispredicted
load_use_stall  in  1  ID needs a result not yet available
imem_ready  in  1  instruction fetch completes this cycle
dmem_busy  in  1  data memory access in MEM has not completed
halt_id  in  1  HLT decoded in ID (register 0 holds HLT)
pc_write  out  1  PC update enable
stage_write  out  NUM_STAGES  per-register write enable
stage_flush  out  NUM_STAGES  per-register bubble insert; only meaningful where stage_write=1
halted  out  1  CPU halted
seq_state  out  2  RUN=0, DRAIN=1, HALTED=2
stall_cnt  out  CNT_W  cycles with pc_write=0 while in RUN
flush_cnt  out  CNT_W  number of mispredict flush events

Behaviour:
- Reset (synchronous, checked first) has priority over every other input:
  - seq_state=RUN, halted=0, counters=0, drain_idx=0.
  - Outputs are combinational from state and inputs, so during reset: pc_write=0, stage_write=all 0, stage_flush=all 0.
- RUN control priority, highest first:
  1. dmem_busy: freeze everything; pc_write=0, stage_write=0, stage_flush=0. Mispredict inputs are ignored because they stay asserted after the freeze.
  2. branch_mispredict: pc_write=1; stage_flush[0..BR_STAGE-1]=1 with write=1; registers ≥BR_STAGE advance normally.
  3. load_use_stall: pc_write=0; registers 0..JMP_STAGE-1... specifically, register 0 holds (write=0); register 1 gets a bubble; registers ≥2 advance.
  4. jump_mispredict: pc_write=1; flush registers 0..JMP_STAGE-1; the rest advance.
  5. !imem_ready: pc_write=0; register 0 gets a bubble; the rest advance.
  6. Otherwise: pc_write=1, all stage_write=1, stage_flush=0.
- Halt entry:
  - In RUN, halt_id with no dmem_busy, branch_mispredict, load_use_stall or jump_mispredict active → next state DRAIN, drain_idx=1.
  - halt_id is ignored in a cycle whose ID contents are being flushed or held.
- DRAIN:
  - pc_write=0; register 0 gets a bubble each cycle; dmem_busy and branch_mispredict rules still apply to registers ≥1.
  - drain_idx tracks the register holding HLT. It increments on each non-frozen cycle.
  - If branch_mispredict occurs and drain_idx < BR_STAGE, the HLT was wrong-path: return to RUN and apply the RUN branch response that cycle.
  - When drain_idx == NUM_STAGES-1 on a non-frozen cycle, go to HALTED.
- HALTED: all outputs 0 except halted=1 and seq_state=2. Only reset leaves this state.
- Counters:
  - stall_cnt increments on RUN cycles with pc_write=0.
  - flush_cnt increments on each cycle that takes priority case 2 or 4 (including a branch flush taken in DRAIN).
  - Both saturate at all-ones and do not wrap.

Decomposition:
- Shared package: seq_state encodings, the register index constants (IDX_IFID, IDX_IDEX, IDX_EXMEM), and the priority-case enumeration.
- One natural sub-module, sat_counter (width parameter, inc, synchronous reset), instantiated twice.

Test Plan:
1. Reset held 2 cycles with all inputs 1 → pc_write=0, stage_write=0, halted=0, counters=0; first cycle after reset with clean inputs → pc_write=1, stage_write=4'b1111.
2. branch_mispredict=1 and load_use_stall=1 together (defaults) → stage_flush=4'b0011, pc_write=1, flush_cnt 0→1; stall_cnt unchanged.
3. dmem_busy=1 for 3 cycles together with branch_mispredict → pc_write=0, stage_write=0 for all 3 cycles; flush applied on the 4th cycle; stall_cnt=3.
4. halt_id in clean RUN (NUM_STAGES=4) → DRAIN for 3 cycles, then seq_state=2, halted=1 on the 4th cycle; stays HALTED under random inputs.
5. halt_id, then branch_mispredict the next cycle (drain_idx=1 < BR_STAGE) → back to RUN, stage_flush=4'b0011, halted never 1.
6. NUM_STAGES=6, BR_STAGE=3, JMP_STAGE=2, jump_mispredict → stage_flush=6'b000011; stall_cnt forced to saturate at 16'hFFFF and held there.

Source files
------------

// File: rtl/pipe_hazard_sequencer_pkg.sv
// Shared encodings for the pipeline hazard sequencer: FSM states,
// pipeline register indices and the per-cycle control priority case.
package pipe_hazard_sequencer_pkg;

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    localparam int IDX_IFID  = 0;
    localparam int IDX_IDEX  = 1;
    localparam int IDX_EXMEM = 2;

    typedef enum logic [3:0] {
        PRI_RESET,
        PRI_FREEZE,
        PRI_BRANCH,
        PRI_LOADUSE,
        PRI_JUMP,
        PRI_IMEM,
        PRI_NORMAL,
        PRI_DRAIN,
        PRI_HALT
    } prio_e;

endpackage

// File: rtl/pipe_hazard_sequencer_sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + W'(1);
    end

endmodule

// File: rtl/pipe_hazard_sequencer.sv
// Registered flush/stall sequencer: per-register write/flush control,
// halt drain with wrong-path cancel, and stall/flush performance counters.
module pipe_hazard_sequencer
    import pipe_hazard_sequencer_pkg::*;
#(
    parameter int NUM_STAGES = 4,
    parameter int BR_STAGE   = 2,
    parameter int JMP_STAGE  = 1,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  branch_mispredict,
    input  logic                  jump_mispredict,
    input  logic                  load_use_stall,
    input  logic                  imem_ready,
    input  logic                  dmem_busy,
    input  logic                  halt_id,
    output logic                  pc_write,
    output logic [NUM_STAGES-1:0] stage_write,
    output logic [NUM_STAGES-1:0] stage_flush,
    output logic                  halted,
    output logic [1:0]            seq_state,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    localparam int IW = $clog2(NUM_STAGES);
    localparam logic [NUM_STAGES-1:0] BR_MASK  = NUM_STAGES'((1 << BR_STAGE) - 1);
    localparam logic [NUM_STAGES-1:0] JMP_MASK = NUM_STAGES'((1 << JMP_STAGE) - 1);
    localparam logic [IW-1:0] BR_IDX   = IW'(BR_STAGE);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_STAGES - 1);

    logic [1:0]    state, next_state;
    logic [IW-1:0] drain_idx, next_idx;
    prio_e         prio;
    logic          flush_ev;
    logic          stall_inc;

    always_comb begin
        prio        = PRI_RESET;
        pc_write    = 1'b0;
        stage_write = '0;
        stage_flush = '0;
        next_state  = state;
        next_idx    = drain_idx;
        flush_ev    = 1'b0;
        if (!reset) begin
            case (state)
                ST_RUN: begin
                    if (dmem_busy)              prio = PRI_FREEZE;
                    else if (branch_mispredict) prio = PRI_BRANCH;
                    else if (load_use_stall)    prio = PRI_LOADUSE;
                    else if (jump_mispredict)   prio = PRI_JUMP;
                    else if (!imem_ready)       prio = PRI_IMEM;
                    else                        prio = PRI_NORMAL;
                    case (prio)
                        PRI_BRANCH: begin
                            pc_write    = 1'b1;
                            stage_write = '1;
                            stage_flush = BR_MASK;
                            flush_ev    = 1'b1;
                        end
                        PRI_LOADUSE: begin
                            stage_write           = '1;
                            stage_write[IDX_IFID] = 1'b0;
                            stage_flush[IDX_IDEX] = 1'b1;
                        end
                        PRI_JUMP: begin
                            pc_write    = 1'b1;
                            stage_write = '1;
                            stage_flush = JMP_MASK;
                            flush_ev    = 1'b1;
                        end
                        PRI_IMEM: begin
                            stage_write           = '1;
                            stage_flush[IDX_IFID] = 1'b1;
                        end
                        PRI_NORMAL: begin
                            pc_write    = 1'b1;
                            stage_write = '1;
                        end
                        default: ;
                    endcase
                    // A missing fetch only bubbles IF/ID; the HLT in ID still advances.
                    if (halt_id && (prio == PRI_IMEM || prio == PRI_NORMAL)) begin
                        next_state = ST_DRAIN;
                        next_idx   = IW'(1);
                    end
                end
                ST_DRAIN: begin
                    stage_write[IDX_IFID] = 1'b1;
                    stage_flush[IDX_IFID] = 1'b1;
                    if (dmem_busy) begin
                        prio = PRI_FREEZE;
                    end else if (branch_mispredict && (drain_idx < BR_IDX)) begin
                        // HLT is younger than the mispredicted branch: it was wrong-path.
                        prio        = PRI_BRANCH;
                        pc_write    = 1'b1;
                        stage_write = '1;
                        stage_flush = BR_MASK;
                        flush_ev    = 1'b1;
                        next_state  = ST_RUN;
                        next_idx    = '0;
                    end else begin
                        prio        = PRI_DRAIN;
                        stage_write = '1;
                        if (branch_mispredict) begin
                            stage_flush = stage_flush | BR_MASK;
                            flush_ev    = 1'b1;
                        end
                        next_idx = drain_idx + IW'(1);
                        if (drain_idx == LAST_IDX)
                            next_state = ST_HALTED;
                    end
                end
                ST_HALTED: prio = PRI_HALT;
                default: begin
                    next_state = ST_RUN;
                    next_idx   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_RUN;
            drain_idx <= '0;
        end else begin
            state     <= next_state;
            drain_idx <= next_idx;
        end
    end

    assign seq_state = state;
    assign halted    = !reset && (state == ST_HALTED);
    assign stall_inc = !reset && (state == ST_RUN) && !pc_write;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_ev),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_sequencer.sv
// Scenario bench for pipe_hazard_sequencer: a default 4-register instance and a
// 6-register instance share stimulus; expected outputs go through scoreboards.
module tb_pipe_hazard_sequencer;

    typedef struct packed {
        logic        pc;
        logic [3:0]  sw;
        logic [3:0]  sf;
        logic [1:0]  st;
        logic        h;
        logic [15:0] sc;
        logic [15:0] fc;
    } obs_t;

    typedef struct packed {
        logic        pc;
        logic [5:0]  sw;
        logic [5:0]  sf;
        logic [1:0]  st;
        logic        h;
        logic [15:0] sc;
        logic [15:0] fc;
    } obs6_t;

    // stimulus bits: {br, jmp, lus, imem, busy, halt}
    localparam logic [5:0] I_BR   = 6'b100000;
    localparam logic [5:0] I_JMP  = 6'b010000;
    localparam logic [5:0] I_LUS  = 6'b001000;
    localparam logic [5:0] I_IMEM = 6'b000100;
    localparam logic [5:0] I_BUSY = 6'b000010;
    localparam logic [5:0] I_HALT = 6'b000001;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic br = 1'b1, jmp = 1'b1, lus = 1'b1, imem = 1'b1, busy = 1'b1, halt = 1'b1;

    logic        pc_write, halted;
    logic [3:0]  stage_write, stage_flush;
    logic [1:0]  seq_state;
    logic [15:0] stall_cnt, flush_cnt;

    logic        pc_write6, halted6;
    logic [5:0]  stage_write6, stage_flush6;
    logic [1:0]  seq_state6;
    logic [15:0] stall_cnt6, flush_cnt6;

    int checks = 0;
    int errors = 0;
    obs_t  sb[$];
    obs6_t sb6[$];

    always #5 clk = ~clk;

    pipe_hazard_sequencer u_dut (
        .clk (clk), .reset (reset),
        .branch_mispredict (br), .jump_mispredict (jmp), .load_use_stall (lus),
        .imem_ready (imem), .dmem_busy (busy), .halt_id (halt),
        .pc_write (pc_write), .stage_write (stage_write), .stage_flush (stage_flush),
        .halted (halted), .seq_state (seq_state),
        .stall_cnt (stall_cnt), .flush_cnt (flush_cnt)
    );

    pipe_hazard_sequencer #(.NUM_STAGES(6), .BR_STAGE(3), .JMP_STAGE(2), .CNT_W(16)) u_dut6 (
        .clk (clk), .reset (reset),
        .branch_mispredict (br), .jump_mispredict (jmp), .load_use_stall (lus),
        .imem_ready (imem), .dmem_busy (busy), .halt_id (halt),
        .pc_write (pc_write6), .stage_write (stage_write6), .stage_flush (stage_flush6),
        .halted (halted6), .seq_state (seq_state6),
        .stall_cnt (stall_cnt6), .flush_cnt (flush_cnt6)
    );

    function automatic obs_t mk(logic p, logic [3:0] w, logic [3:0] f, logic [1:0] s,
                                logic hh, logic [15:0] sc, logic [15:0] fc);
        obs_t o;
        o.pc = p; o.sw = w; o.sf = f; o.st = s; o.h = hh; o.sc = sc; o.fc = fc;
        return o;
    endfunction

    function automatic obs6_t mk6(logic p, logic [5:0] w, logic [5:0] f, logic [1:0] s,
                                  logic hh, logic [15:0] sc, logic [15:0] fc);
        obs6_t o;
        o.pc = p; o.sw = w; o.sf = f; o.st = s; o.h = hh; o.sc = sc; o.fc = fc;
        return o;
    endfunction

    function automatic obs_t snap();
        return mk(pc_write, stage_write, stage_flush, seq_state, halted, stall_cnt, flush_cnt);
    endfunction

    function automatic obs6_t snap6();
        return mk6(pc_write6, stage_write6, stage_flush6, seq_state6, halted6, stall_cnt6, flush_cnt6);
    endfunction

    task automatic set_in(logic [5:0] v);
        {br, jmp, lus, imem, busy, halt} = v;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_in(I_IMEM);
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic       rst [3]  = '{1'b1, 1'b1, 1'b0};
        logic [5:0] ins [3]  = '{6'h3F, 6'h3F, I_IMEM};
        obs_t       want [3];
        obs_t got, e;
        want = '{mk(1'b0, 4'h0, 4'h0, 2'd0, 1'b0, 16'd0, 16'd0),
                 mk(1'b0, 4'h0, 4'h0, 2'd0, 1'b0, 16'd0, 16'd0),
                 mk(1'b1, 4'hF, 4'h0, 2'd0, 1'b0, 16'd0, 16'd0)};
        reset = 1'b1; set_in(6'h3F);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            reset = rst[i]; set_in(ins[i]); sb.push_back(want[i]);
            @(negedge clk);
            got = snap(); e = sb.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL reset[%0d]: got %h want %h", i, got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mispredict();
        logic [5:0] ins [5] = '{I_BR|I_LUS|I_IMEM, I_LUS|I_JMP|I_IMEM, I_JMP, 6'b0, I_IMEM};
        obs_t want [5];
        obs_t got, e;
        want = '{mk(1'b1, 4'hF, 4'h3, 2'd0, 1'b0, 16'd0, 16'd0),
                 mk(1'b0, 4'hE, 4'h2, 2'd0, 1'b0, 16'd0, 16'd1),
                 mk(1'b1, 4'hF, 4'h1, 2'd0, 1'b0, 16'd1, 16'd1),
                 mk(1'b0, 4'hF, 4'h1, 2'd0, 1'b0, 16'd1, 16'd2),
                 mk(1'b1, 4'hF, 4'h0, 2'd0, 1'b0, 16'd2, 16'd2)};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_in(ins[i]); sb.push_back(want[i]);
            @(negedge clk);
            got = snap(); e = sb.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL mispredict[%0d]: got %h want %h", i, got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_freeze();
        logic [5:0] ins [5] = '{I_BUSY|I_BR|I_IMEM, I_BUSY|I_BR|I_IMEM, I_BUSY|I_BR|I_IMEM,
                                I_BR|I_IMEM, I_IMEM};
        obs_t want [5];
        obs_t got, e;
        want = '{mk(1'b0, 4'h0, 4'h0, 2'd0, 1'b0, 16'd0, 16'd0),
                 mk(1'b0, 4'h0, 4'h0, 2'd0, 1'b0, 16'd1, 16'd0),
                 mk(1'b0, 4'h0, 4'h0, 2'd0, 1'b0, 16'd2, 16'd0),
                 mk(1'b1, 4'hF, 4'h3, 2'd0, 1'b0, 16'd3, 16'd0),
                 mk(1'b1, 4'hF, 4'h0, 2'd0, 1'b0, 16'd3, 16'd1)};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_in(ins[i]); sb.push_back(want[i]);
            @(negedge clk);
            got = snap(); e = sb.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL freeze[%0d]: got %h want %h", i, got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_halt();
        logic [5:0] ins [7] = '{I_HALT|I_LUS|I_IMEM, I_IMEM, I_HALT|I_IMEM,
                                I_IMEM, I_IMEM, I_IMEM, I_IMEM};
        obs_t want [7];
        obs_t got, e;
        want = '{mk(1'b0, 4'hE, 4'h2, 2'd0, 1'b0, 16'd0, 16'd0),
                 mk(1'b1, 4'hF, 4'h0, 2'd0, 1'b0, 16'd1, 16'd0),
                 mk(1'b1, 4'hF, 4'h0, 2'd0, 1'b0, 16'd1, 16'd0),
                 mk(1'b0, 4'hF, 4'h1, 2'd1, 1'b0, 16'd1, 16'd0),
                 mk(1'b0, 4'hF, 4'h1, 2'd1, 1'b0, 16'd1, 16'd0),
                 mk(1'b0, 4'hF, 4'h1, 2'd1, 1'b0, 16'd1, 16'd0),
                 mk(1'b0, 4'h0, 4'h0, 2'd2, 1'b1, 16'd1, 16'd0)};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            set_in(ins[i]); sb.push_back(want[i]);
            @(negedge clk);
            got = snap(); e = sb.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL halt[%0d]: got %h want %h", i, got, e);
            end
            @(posedge clk); #1;
        end
        for (int i = 0; i < 6; i++) begin
            set_in(6'($urandom));
            sb.push_back(mk(1'b0, 4'h0, 4'h0, 2'd2, 1'b1, 16'd1, 16'd0));
            @(negedge clk);
            got = snap(); e = sb.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL halted_hold[%0d]: got %h want %h", i, got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_cancel();
        logic [5:0] ins [5] = '{I_HALT|I_IMEM, I_BR|I_IMEM, I_IMEM, I_IMEM, I_IMEM};
        obs_t want [5];
        obs_t got, e;
        want = '{mk(1'b1, 4'hF, 4'h0, 2'd0, 1'b0, 16'd0, 16'd0),
                 mk(1'b1, 4'hF, 4'h3, 2'd1, 1'b0, 16'd0, 16'd0),
                 mk(1'b1, 4'hF, 4'h0, 2'd0, 1'b0, 16'd0, 16'd1),
                 mk(1'b1, 4'hF, 4'h0, 2'd0, 1'b0, 16'd0, 16'd1),
                 mk(1'b1, 4'hF, 4'h0, 2'd0, 1'b0, 16'd0, 16'd1)};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_in(ins[i]); sb.push_back(want[i]);
            @(negedge clk);
            got = snap(); e = sb.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL cancel[%0d]: got %h want %h", i, got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_drain_late();
        logic [5:0] ins [6] = '{I_HALT|I_IMEM, I_IMEM, I_BUSY|I_BR|I_IMEM,
                                I_BR|I_IMEM, I_IMEM, I_IMEM};
        obs_t want [6];
        obs_t got, e;
        want = '{mk(1'b1, 4'hF, 4'h0, 2'd0, 1'b0, 16'd0, 16'd0),
                 mk(1'b0, 4'hF, 4'h1, 2'd1, 1'b0, 16'd0, 16'd0),
                 mk(1'b0, 4'h1, 4'h1, 2'd1, 1'b0, 16'd0, 16'd0),
                 mk(1'b0, 4'hF, 4'h3, 2'd1, 1'b0, 16'd0, 16'd0),
                 mk(1'b0, 4'hF, 4'h1, 2'd1, 1'b0, 16'd0, 16'd1),
                 mk(1'b0, 4'h0, 4'h0, 2'd2, 1'b1, 16'd0, 16'd1)};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            set_in(ins[i]); sb.push_back(want[i]);
            @(negedge clk);
            got = snap(); e = sb.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL drain_late[%0d]: got %h want %h", i, got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_wide_saturate();
        logic [5:0] ins [3] = '{I_JMP|I_IMEM, I_BR|I_IMEM, I_LUS|I_IMEM};
        obs6_t want [3];
        obs6_t got, e;
        want = '{mk6(1'b1, 6'h3F, 6'h03, 2'd0, 1'b0, 16'd0, 16'd0),
                 mk6(1'b1, 6'h3F, 6'h07, 2'd0, 1'b0, 16'd0, 16'd1),
                 mk6(1'b0, 6'h3E, 6'h02, 2'd0, 1'b0, 16'd0, 16'd2)};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(ins[i]); sb6.push_back(want[i]);
            @(negedge clk);
            got = snap6(); e = sb6.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL wide[%0d]: got %h want %h", i, got, e);
            end
            @(posedge clk); #1;
        end
        // one stall already counted; run far enough past 16'hFFFF to prove it sticks
        set_in(6'b0);
        repeat (65540) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            set_in(6'b0);
            sb6.push_back(mk6(1'b0, 6'h3F, 6'h01, 2'd0, 1'b0, 16'hFFFF, 16'd2));
            @(negedge clk);
            got = snap6(); e = sb6.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL saturate[%0d]: got %h want %h", i, got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_mispredict();
        test_freeze();
        test_halt();
        test_cancel();
        test_drain_late();
        test_wide_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
